// File: rtl/ksa32_result_stage.sv
// Registered output stage for the 32-bit Kogge-Stone adder: 2-entry skid buffer with
// valid/ready handshake, zero flag, and saturating result/carry/overflow statistics.
module ksa32_result_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_cout,
  input  logic             in_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] res_count,
  output logic [CNT_W-1:0] cout_count,
  output logic [CNT_W-1:0] ovf_count,
  output logic             ovf_sticky
);

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
  } entry_t;

  entry_t main_reg, main_next;
  entry_t skid_reg, skid_next;
  entry_t in_entry;
  logic   main_valid_reg, main_valid_next;
  logic   skid_valid_reg, skid_valid_next;
  logic   in_ready_reg;
  logic   acc, take;

  assign acc      = in_valid & in_ready_reg;
  assign take     = main_valid_reg & out_ready;
  assign in_entry = '{sum: in_sum, cout: in_cout, ovf: in_ovf, zero: (in_sum == '0)};

  always_comb begin
    main_next       = main_reg;
    main_valid_next = main_valid_reg;
    skid_next       = skid_reg;
    skid_valid_next = skid_valid_reg;
    if (take && skid_valid_reg) begin
      main_next       = skid_reg;
      skid_valid_next = 1'b0;
    end else if (acc && (!main_valid_reg || take)) begin
      main_next       = in_entry;
      main_valid_next = 1'b1;
    end else if (take) begin
      main_valid_next = 1'b0;
    end
    // Skid only fills when main is occupied and stalled; in_ready guarantees it is empty.
    if (acc && main_valid_reg && !take) begin
      skid_next       = in_entry;
      skid_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_reg       <= '0;
      skid_reg       <= '0;
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      in_ready_reg   <= 1'b1;
    end else begin
      main_reg       <= main_next;
      skid_reg       <= skid_next;
      main_valid_reg <= main_valid_next;
      skid_valid_reg <= skid_valid_next;
      in_ready_reg   <= !skid_valid_next;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = main_valid_reg;
  assign out_sum   = main_reg.sum;
  assign out_cout  = main_reg.cout;
  assign out_ovf   = main_reg.ovf;
  assign out_zero  = main_reg.zero;

  // Counter 0: every accept, 1: accepts with carry-out, 2: accepts with overflow.
  logic [2:0]         cnt_inc;
  logic [3*CNT_W-1:0] cnt_flat;
  assign cnt_inc = {in_ovf, in_cout, 1'b1};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (clr_stats) begin
          cnt_reg <= '0;
        end else if (acc && cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
      assign cnt_flat[gi*CNT_W +: CNT_W] = cnt_reg;
    end
  endgenerate

  assign res_count  = cnt_flat[0*CNT_W +: CNT_W];
  assign cout_count = cnt_flat[1*CNT_W +: CNT_W];
  assign ovf_count  = cnt_flat[2*CNT_W +: CNT_W];

  logic sticky_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_reg <= 1'b0;
    end else if (clr_stats) begin
      sticky_reg <= 1'b0;
    end else if (acc && in_ovf) begin
      sticky_reg <= 1'b1;
    end
  end
  assign ovf_sticky = sticky_reg;

endmodule

// File: tb/tb_ksa32_result_stage.sv
// Self-checking bench for ksa32_result_stage: scoreboard of accepted results compared
// against every output take, plus per-scenario checks of handshake, flags and counters.
module tb_ksa32_result_stage;
  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum = '0;
  logic             in_cout = 1'b0;
  logic             in_ovf = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout, out_ovf, out_zero;
  logic             clr_stats = 1'b0;
  logic [CNT_W-1:0] res_count, cout_count, ovf_count;
  logic             ovf_sticky;

  int checks = 0;
  int errors = 0;

  logic [WIDTH+2:0] exp_q[$];
  logic [WIDTH+2:0] held;
  logic             stalled = 1'b0;

  always #5 clk = ~clk;

  ksa32_result_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_cout(in_cout), .in_ovf(in_ovf),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero),
    .clr_stats(clr_stats),
    .res_count(res_count), .cout_count(cout_count), .ovf_count(ovf_count),
    .ovf_sticky(ovf_sticky)
  );

  // Scoreboard: sampled on the falling edge, mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (stalled) begin
        checks++;
        if (!out_valid || {out_sum, out_cout, out_ovf, out_zero} !== held) begin
          errors++;
          $display("FAIL stall_hold: got valid=%0b %h required valid=1 %h", out_valid,
                   {out_sum, out_cout, out_ovf, out_zero}, held);
        end
      end
      stalled = out_valid && !out_ready;
      held    = {out_sum, out_cout, out_ovf, out_zero};
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: got sum=%h with empty scoreboard", out_sum);
        end else begin
          logic [WIDTH+2:0] e;
          e = exp_q.pop_front();
          if ({out_sum, out_cout, out_ovf, out_zero} !== e) begin
            errors++;
            $display("FAIL sb_data: got sum=%h c=%0b o=%0b z=%0b required sum=%h c=%0b o=%0b z=%0b",
                     out_sum, out_cout, out_ovf, out_zero, e[WIDTH+2:3], e[2], e[1], e[0]);
          end else begin
            $display("take sum=%h c=%0b o=%0b z=%0b", out_sum, out_cout, out_ovf, out_zero);
          end
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back({in_sum, in_cout, in_ovf, (in_sum == '0)});
    end else begin
      stalled = 1'b0;
    end
  end

  // Present one result and return #1 after the edge that accepted it.
  task automatic send(input logic [WIDTH-1:0] s, input logic c, input logic o);
    bit done = 0;
    in_valid = 1'b1; in_sum = s; in_cout = c; in_ovf = o;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk); #1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout: got in_ready=0 required accept of %h", s);
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; clr_stats = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== '0 || res_count !== '0 ||
        cout_count !== '0 || ovf_count !== '0 || ovf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got ov=%0b ir=%0b sum=%h rc=%0d cc=%0d oc=%0d st=%0b required ov=0 ir=1 all 0",
               out_valid, in_ready, out_sum, res_count, cout_count, ovf_count, ovf_sticky);
    end
    $display("reset checked");
  endtask

  task automatic test_stream();
    logic [WIDTH-1:0] vals[3] = '{32'h00000003, 32'h80000000, 32'h00000000};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(vals[i], 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_sum !== vals[i] || out_zero !== (i == 2)) begin
        errors++;
        $display("FAIL stream_latency: got ov=%0b sum=%h z=%0b required ov=1 sum=%h z=%0b",
                 out_valid, out_sum, out_zero, vals[i], (i == 2));
      end
    end
    idle(3);
    checks++;
    if (res_count !== 4'd3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stream_count: got rc=%0d pending=%0d required rc=3 pending=0", res_count, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(32'hAAAA5555, 1'b0, 1'b0);
    send(32'h12345678, 1'b0, 1'b0);
    checks++;
    if (in_ready !== 1'b0 || out_sum !== 32'hAAAA5555) begin
      errors++;
      $display("FAIL bp_full: got ir=%0b sum=%h required ir=0 sum=aaaa5555", in_ready, out_sum);
    end
    idle(3);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 32'hAAAA5555 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: got ov=%0b sum=%h ir=%0b required ov=1 sum=aaaa5555 ir=0",
               out_valid, out_sum, in_ready);
    end
    out_ready = 1'b1;
    idle(1);
    checks++;
    if (out_sum !== 32'h12345678 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain: got sum=%h ir=%0b required sum=12345678 ir=1", out_sum, in_ready);
    end
    idle(2);
    checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_empty: got ov=%0b pending=%0d required ov=0 pending=0", out_valid, exp_q.size());
    end
  endtask

  task automatic test_flags();
    do_reset();
    out_ready = 1'b1;
    send(32'h00000000, 1'b1, 1'b1);
    checks++;
    if (out_cout !== 1'b1 || out_ovf !== 1'b1 || out_zero !== 1'b1 || cout_count !== 4'd1 ||
        ovf_count !== 4'd1 || ovf_sticky !== 1'b1) begin
      errors++;
      $display("FAIL flags_ovf: got c=%0b o=%0b z=%0b cc=%0d oc=%0d st=%0b required 1 1 1 1 1 1",
               out_cout, out_ovf, out_zero, cout_count, ovf_count, ovf_sticky);
    end
    send(32'h00000000, 1'b1, 1'b0);
    checks++;
    if (out_zero !== 1'b1 || out_cout !== 1'b1 || out_ovf !== 1'b0 || ovf_count !== 4'd1 ||
        cout_count !== 4'd2 || res_count !== 4'd2) begin
      errors++;
      $display("FAIL flags_carry_zero: got z=%0b c=%0b o=%0b oc=%0d cc=%0d rc=%0d required 1 1 0 1 2 2",
               out_zero, out_cout, out_ovf, ovf_count, cout_count, res_count);
    end
    idle(2);
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(32'h100 + i, 1'b1, 1'b0);
      if (i == 14 || i == 19) begin
        checks++;
        if (res_count !== 4'd15 || cout_count !== 4'd15 || ovf_count !== 4'd0) begin
          errors++;
          $display("FAIL saturate_%0d: got rc=%0d cc=%0d oc=%0d required 15 15 0", i, res_count,
                   cout_count, ovf_count);
        end
      end
    end
    idle(2);
  endtask

  task automatic test_clr_stats();
    out_ready = 1'b1;
    send(32'h00000042, 1'b0, 1'b1);
    checks++;
    if (ovf_sticky !== 1'b1) begin
      errors++;
      $display("FAIL clr_pre_sticky: got %0b required 1", ovf_sticky);
    end
    clr_stats = 1'b1;
    send(32'h0BADF00D, 1'b1, 1'b1);
    clr_stats = 1'b0;
    checks++;
    if (res_count !== '0 || cout_count !== '0 || ovf_count !== '0 || ovf_sticky !== 1'b0 ||
        out_valid !== 1'b1 || out_sum !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL clr_coincident: got rc=%0d cc=%0d oc=%0d st=%0b ov=%0b sum=%h required 0 0 0 0 1 0badf00d",
               res_count, cout_count, ovf_count, ovf_sticky, out_valid, out_sum);
    end
    idle(2);
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send(32'h11111111, 1'b0, 1'b0);
    send(32'h22222222, 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || res_count !== '0 || ovf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got ov=%0b ir=%0b rc=%0d st=%0b required ov=0 ir=1 rc=0 st=0",
               out_valid, in_ready, res_count, ovf_sticky);
    end
    exp_q.delete();
    @(negedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;
    idle(4);
    checks++;
    if (out_valid !== 1'b0 || res_count !== '0) begin
      errors++;
      $display("FAIL reset_stale: got ov=%0b sum=%h rc=%0d required ov=0 rc=0", out_valid, out_sum, res_count);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flags();
    test_saturation();
    test_clr_stats();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
